// File: rtl/mtsp_command_mq.sv
// mtsp_command_mq: multi-channel host command processor for the MTSP core.
// CH_COUNT command FIFOs are filled by the host slave bus. A round-robin arbiter
// dispatches at most one command per cycle into memory-descriptor, thread-start,
// video-base and interrupt controls. Each channel can wait on {mem, busy} or on a fence.
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   BUSY                 system busy input (status and wait mask)
//   BUS_EN/WE/ADDR/WDATA host access; ADDR = {channel, cmd}
//   BUS_READY, BUS_RDATA write back-pressure and combinational status read
//   MEM_EN, MEM_DESC     pending memory request and its descriptor; MEM_VALID accepts it
//   THREAD_EN/OP/PC      one-cycle thread start
//   VIDEO_BASE           screen base address
//   CACHE_LUT_CLEAR      cache LUT clear pulse (held high in reset)
//   INTR, INTR_CH        one-cycle interrupt and originating channel
module mtsp_command_mq #(
    parameter int unsigned CH_COUNT    = 2,
    parameter int unsigned QUEUE_DEPTH = 6,
    parameter int unsigned DESC_WORDS  = 4,
    localparam int unsigned CHW        = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    BUSY,
    input  logic                    BUS_EN,
    input  logic                    BUS_WE,
    input  logic [CHW+3:0]          BUS_ADDR,
    input  logic [31:0]             BUS_WDATA,
    output logic                    BUS_READY,
    output logic [31:0]             BUS_RDATA,
    output logic                    MEM_EN,
    output logic [32*DESC_WORDS-1:0] MEM_DESC,
    input  logic                    MEM_VALID,
    output logic                    THREAD_EN,
    output logic                    THREAD_OP,
    output logic [29:0]             THREAD_PC,
    output logic [31:0]             VIDEO_BASE,
    output logic                    CACHE_LUT_CLEAR,
    output logic                    INTR,
    output logic [CHW-1:0]          INTR_CH
);
    localparam int unsigned ENTRIES    = 1 << QUEUE_DEPTH;
    localparam int unsigned PW         = QUEUE_DEPTH + 1;
    localparam int unsigned DW         = $clog2(DESC_WORDS);
    localparam logic [3:0]  LAUNCH_CMD = 4'(DESC_WORDS - 1);

    logic [35:0]             fifo_mem [CH_COUNT][ENTRIES];
    logic [PW-1:0]           wr_ptr_q [CH_COUNT];
    logic [PW-1:0]           rd_ptr_q [CH_COUNT];
    logic [7:0]              wcount_q [CH_COUNT];
    logic [7:0]              rcount_q [CH_COUNT];
    logic [31:0]             fence_q  [CH_COUNT];
    logic [31:0]             desc_q   [CH_COUNT][DESC_WORDS];
    logic [CH_COUNT-1:0]     wait_q;
    logic [CH_COUNT-1:0]     wait_fence_q;   // 1: fence wait, 0: {mem, busy} mask wait
    logic [1:0]              mask_q   [CH_COUNT];
    logic [CHW-1:0]          wtgt_q   [CH_COUNT];
    logic [27:0]             wval_q   [CH_COUNT];
    logic [CHW-1:0]          rr_q;
    logic                    mem_en_q;
    logic [32*DESC_WORDS-1:0] mem_desc_q;
    logic                    thread_en_q, thread_op_q, video_dummy;
    logic [29:0]             thread_pc_q;
    logic [31:0]             video_q;
    logic                    clear_q, intr_q;
    logic [CHW-1:0]          intr_ch_q;

    logic [CHW-1:0]          bus_ch;
    logic [3:0]              bus_cmd;
    logic                    ch_ok, wr_fire;
    logic [CH_COUNT-1:0]     full, empty, elig;
    logic [3:0]              head_cmd  [CH_COUNT];
    logic [31:0]             head_data [CH_COUNT];
    logic                    grant_valid;
    logic [CHW-1:0]          grant;
    int unsigned             arb_idx;
    logic [3:0]              g_cmd;
    logic [31:0]             g_data;
    logic [32*DESC_WORDS-1:0] launch_desc;

    assign video_dummy = 1'b0;
    assign bus_ch  = BUS_ADDR[CHW+3:4];
    assign bus_cmd = BUS_ADDR[3:0];

    // Channel numbers beyond CH_COUNT only exist when CH_COUNT is not a power of two.
    if ((1 << CHW) == CH_COUNT) begin : g_pow2
        assign ch_ok = 1'b1;
    end else begin : g_npow2
        assign ch_ok = (32'(bus_ch) < CH_COUNT);
    end

    always_comb begin
        for (int c = 0; c < CH_COUNT; c++) begin
            empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            full[c]  = (wr_ptr_q[c][PW-1] != rd_ptr_q[c][PW-1]) &&
                       (wr_ptr_q[c][PW-2:0] == rd_ptr_q[c][PW-2:0]);
            {head_cmd[c], head_data[c]} = fifo_mem[c][rd_ptr_q[c][PW-2:0]];
            // A launch at the head waits in the FIFO while the previous one is pending.
            elig[c] = ~empty[c] & ~wait_q[c] & ~((head_cmd[c] == LAUNCH_CMD) & mem_en_q);
        end
    end

    assign wr_fire   = BUS_EN & BUS_WE & ch_ok & ~full[bus_ch];
    assign BUS_READY = ch_ok ? (~full[bus_ch] | (BUS_EN & ~BUS_WE)) : 1'b1;

    always_comb begin
        BUS_RDATA = '0;
        if (ch_ok) begin
            case (bus_cmd)
                4'd0: BUS_RDATA = {wcount_q[bus_ch], rcount_q[bus_ch], 8'(QUEUE_DEPTH), 3'b000,
                                   wait_q[bus_ch], full[bus_ch], empty[bus_ch], mem_en_q, BUSY};
                4'd1: BUS_RDATA = fence_q[bus_ch];
                default: BUS_RDATA = '0;
            endcase
        end
    end

    // Round-robin: first eligible channel at or above rr_q, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        arb_idx     = 0;
        for (int i = 0; i < CH_COUNT; i++) begin
            arb_idx = 32'(rr_q) + 32'(i);
            if (arb_idx >= CH_COUNT) arb_idx = arb_idx - CH_COUNT;
            if (!grant_valid && elig[CHW'(arb_idx)]) begin
                grant_valid = 1'b1;
                grant       = CHW'(arb_idx);
            end
        end
    end

    assign g_cmd  = head_cmd[grant];
    assign g_data = head_data[grant];

    always_comb begin
        launch_desc = '0;
        for (int k = 0; k < DESC_WORDS; k++) launch_desc[32*k +: 32] = desc_q[grant][k];
        launch_desc[32*(DESC_WORDS-1) +: 32] = g_data;
    end

    always_ff @(posedge CLK) begin
        if (wr_fire) fifo_mem[bus_ch][wr_ptr_q[bus_ch][PW-2:0]] <= {bus_cmd, BUS_WDATA};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int c = 0; c < CH_COUNT; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                wcount_q[c] <= '0;
                rcount_q[c] <= '0;
                fence_q[c]  <= '0;
                mask_q[c]   <= '0;
                wtgt_q[c]   <= '0;
                wval_q[c]   <= '0;
                for (int k = 0; k < DESC_WORDS; k++) desc_q[c][k] <= '0;
            end
            wait_q       <= '0;
            wait_fence_q <= '0;
            rr_q         <= '0;
            mem_en_q     <= 1'b0;
            mem_desc_q   <= '0;
            thread_en_q  <= 1'b0;
            thread_op_q  <= 1'b0;
            thread_pc_q  <= '0;
            video_q      <= '0;
            clear_q      <= 1'b1;
            intr_q       <= 1'b0;
            intr_ch_q    <= '0;
        end else begin
            thread_en_q <= 1'b0;
            intr_q      <= 1'b0;
            clear_q     <= 1'b0;
            if (mem_en_q && MEM_VALID) mem_en_q <= 1'b0;

            if (wr_fire) begin
                wr_ptr_q[bus_ch] <= wr_ptr_q[bus_ch] + 1'b1;
                wcount_q[bus_ch] <= wcount_q[bus_ch] + 8'd1;
            end

            // A waiting channel is never granted, so release and dispatch cannot collide.
            for (int c = 0; c < CH_COUNT; c++) begin
                if (wait_q[c]) begin
                    if (wait_fence_q[c]) begin
                        if (fence_q[wtgt_q[c]][27:0] >= wval_q[c]) wait_q[c] <= 1'b0;
                    end else if ((mask_q[c] & {mem_en_q, BUSY}) == 2'b00) begin
                        wait_q[c] <= 1'b0;
                    end
                end
            end

            if (grant_valid) begin
                rd_ptr_q[grant] <= rd_ptr_q[grant] + 1'b1;
                rcount_q[grant] <= rcount_q[grant] + 8'd1;
                rr_q            <= (grant == CHW'(CH_COUNT - 1)) ? '0 : grant + 1'b1;
                if (g_cmd <= LAUNCH_CMD) begin
                    desc_q[grant][g_cmd[DW-1:0]] <= g_data;
                    if (g_cmd == LAUNCH_CMD) begin
                        mem_en_q   <= 1'b1;
                        mem_desc_q <= launch_desc;
                    end
                end else if (g_cmd == 4'd4) begin
                    thread_en_q <= 1'b1;
                    thread_pc_q <= g_data[31:2];
                    thread_op_q <= g_data[0];
                end else if (g_cmd == 4'd5) begin
                    video_q <= g_data;
                end else if (g_cmd == 4'd9) begin
                    intr_q    <= g_data[0];
                    clear_q   <= g_data[1];
                    intr_ch_q <= grant;
                end else if (g_cmd == 4'd10) begin
                    fence_q[grant] <= g_data;
                end else if (g_cmd == 4'd11) begin
                    wait_q[grant]       <= 1'b1;
                    wait_fence_q[grant] <= 1'b0;
                    mask_q[grant]       <= g_data[1:0];
                end else if (g_cmd == 4'd12) begin
                    wait_q[grant]       <= 1'b1;
                    wait_fence_q[grant] <= 1'b1;
                    wtgt_q[grant]       <= CHW'(32'(g_data[31:28]) % CH_COUNT);
                    wval_q[grant]       <= g_data[27:0];
                end
            end
        end
    end

    assign MEM_EN          = mem_en_q;
    assign MEM_DESC        = mem_desc_q;
    assign THREAD_EN       = thread_en_q;
    assign THREAD_OP       = thread_op_q | video_dummy;
    assign THREAD_PC       = thread_pc_q;
    assign VIDEO_BASE      = video_q;
    assign CACHE_LUT_CLEAR = clear_q;
    assign INTR            = intr_q;
    assign INTR_CH         = intr_ch_q;
endmodule

// File: tb/tb_mtsp_command_mq.sv
// Directed bench for mtsp_command_mq with a scoreboard of expected thread starts,
// video-base updates and memory launches, popped when the DUT produces them.
module tb_mtsp_command_mq;
    localparam int CHW = 1;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         BUSY = 1'b0;
    logic         BUS_EN = 1'b0;
    logic         BUS_WE = 1'b0;
    logic [CHW+3:0] BUS_ADDR = '0;
    logic [31:0]  BUS_WDATA = '0;
    logic         BUS_READY;
    logic [31:0]  BUS_RDATA;
    logic         MEM_EN;
    logic [127:0] MEM_DESC;
    logic         MEM_VALID = 1'b0;
    logic         THREAD_EN, THREAD_OP;
    logic [29:0]  THREAD_PC;
    logic [31:0]  VIDEO_BASE;
    logic         CACHE_LUT_CLEAR, INTR;
    logic [CHW-1:0] INTR_CH;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem_sb[$];
    logic [30:0]  thread_sb[$];
    logic [31:0]  video_sb[$];

    mtsp_command_mq #(.CH_COUNT(2), .QUEUE_DEPTH(6), .DESC_WORDS(4)) dut (
        .CLK(CLK), .nRST(nRST), .BUSY(BUSY),
        .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
        .BUS_READY(BUS_READY), .BUS_RDATA(BUS_RDATA),
        .MEM_EN(MEM_EN), .MEM_DESC(MEM_DESC), .MEM_VALID(MEM_VALID),
        .THREAD_EN(THREAD_EN), .THREAD_OP(THREAD_OP), .THREAD_PC(THREAD_PC),
        .VIDEO_BASE(VIDEO_BASE), .CACHE_LUT_CLEAR(CACHE_LUT_CLEAR),
        .INTR(INTR), .INTR_CH(INTR_CH)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enter at a negedge; returns at the negedge after the write is accepted.
    task automatic bus_write(input logic ch, input logic [3:0] cmd, input logic [31:0] data);
        int n;
        n = 0;
        BUS_EN = 1'b1; BUS_WE = 1'b1; BUS_ADDR = {ch, cmd}; BUS_WDATA = data;
        #1;
        while (!BUS_READY && n < 500) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 500) check("write_ready_timeout", 128'(BUS_READY), 128'd1);
        @(negedge CLK);
        BUS_EN = 1'b0; BUS_WE = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic ch, input logic [3:0] cmd,
                              input logic [31:0] exp);
        BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = {ch, cmd};
        #1;
        check(tag, 128'(BUS_RDATA), 128'(exp));
        BUS_EN = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT emits an event.
    logic [31:0]  prev_video = '0;
    logic         prev_mem_en = 1'b0;
    logic [127:0] prev_desc = '0;
    always @(negedge CLK) begin
        logic [30:0]  t_exp;
        logic [31:0]  v_exp;
        logic [127:0] m_exp;
        if (!nRST) begin
            prev_video  = VIDEO_BASE;
            prev_mem_en = 1'b0;
        end else begin
            if (THREAD_EN) begin
                check("thread_sb_nonempty", 128'(thread_sb.size() != 0), 128'd1);
                if (thread_sb.size() != 0) begin
                    t_exp = thread_sb.pop_front();
                    check("thread_pc_op", 128'({THREAD_PC, THREAD_OP}), 128'(t_exp));
                end
            end
            if (VIDEO_BASE != prev_video) begin
                check("video_sb_nonempty", 128'(video_sb.size() != 0), 128'd1);
                if (video_sb.size() != 0) begin
                    v_exp = video_sb.pop_front();
                    check("video_base", 128'(VIDEO_BASE), 128'(v_exp));
                end
                prev_video = VIDEO_BASE;
            end
            if (MEM_EN && !prev_mem_en) begin
                check("mem_sb_nonempty", 128'(mem_sb.size() != 0), 128'd1);
                if (mem_sb.size() != 0) begin
                    m_exp = mem_sb.pop_front();
                    check("mem_desc_launch", MEM_DESC, m_exp);
                end
            end else if (MEM_EN && prev_mem_en) begin
                check("mem_desc_stable", MEM_DESC, prev_desc);
            end
            prev_mem_en = MEM_EN;
            prev_desc   = MEM_DESC;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_clear", 128'(CACHE_LUT_CLEAR), 128'd1);
        check("rst_mem_en", 128'(MEM_EN), 128'd0);
        check("rst_video", 128'(VIDEO_BASE), 128'd0);
        check("rst_intr", 128'({INTR, INTR_CH, THREAD_EN}), 128'd0);
        #2 nRST = 1'b1;
        @(negedge CLK);
        check("clear_after_rst", 128'(CACHE_LUT_CLEAR), 128'd0);
        check_read("status0_reset", 1'b0, 4'd0, 32'h0000_0604);

        // 1: thread start
        @(negedge CLK);
        thread_sb.push_back({30'h400, 1'b1});
        bus_write(1'b0, 4'd4, 32'h0000_1001);
        check("thread_en_idle", 128'(THREAD_EN), 128'd0);
        @(negedge CLK);
        check("thread_en_pulse", 128'(THREAD_EN), 128'd1);
        @(negedge CLK);
        check("thread_en_end", 128'(THREAD_EN), 128'd0);
        check_read("status0_after_thread", 1'b0, 4'd0, 32'h0101_0604);

        // 2: fill ch1 while it waits on BUSY
        @(negedge CLK);
        BUSY = 1'b1;
        bus_write(1'b1, 4'd11, 32'h1);
        for (int i = 0; i < 64; i++) begin
            video_sb.push_back(32'h100 + 32'(i));
            bus_write(1'b1, 4'd5, 32'h100 + 32'(i));
        end
        check_read("status1_full", 1'b1, 4'd0, 32'h4101_0619);
        BUS_EN = 1'b1; BUS_WE = 1'b1; BUS_ADDR = {1'b1, 4'd5}; BUS_WDATA = 32'h200;
        #1;
        check("ready_low_full", 128'(BUS_READY), 128'd0);
        @(negedge CLK);
        #1;
        check("ready_held_low", 128'(BUS_READY), 128'd0);
        BUS_WE = 1'b0;
        #1;
        check("ready_on_read", 128'(BUS_READY), 128'd1);
        BUS_EN = 1'b0;
        @(negedge CLK);
        BUSY = 1'b0;
        video_sb.push_back(32'h200);
        bus_write(1'b1, 4'd5, 32'h200);
        idle(80);
        check_read("status1_drained", 1'b1, 4'd0, 32'h4242_0604);

        // 3: back-to-back launches with MEM_VALID held low
        @(negedge CLK);
        mem_sb.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
        mem_sb.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
        for (int k = 0; k < 4; k++) bus_write(1'b0, 4'(k), 32'hA0 + 32'(k));
        for (int k = 0; k < 4; k++) bus_write(1'b0, 4'(k), 32'hB0 + 32'(k));
        idle(3);
        check("mem_en_held", 128'(MEM_EN), 128'd1);
        check("mem_desc_first", MEM_DESC, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        check_read("status0_launch_blocked", 1'b0, 4'd0, 32'h0908_0602);
        @(negedge CLK);
        MEM_VALID = 1'b1;
        @(negedge CLK);
        MEM_VALID = 1'b0;
        check("mem_en_fall", 128'(MEM_EN), 128'd0);
        @(negedge CLK);
        check("mem_relaunch", 128'(MEM_EN), 128'd1);
        check("mem_desc_second", MEM_DESC, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        MEM_VALID = 1'b1;
        @(negedge CLK);
        MEM_VALID = 1'b0;
        @(negedge CLK);
        check("mem_en_done", 128'(MEM_EN), 128'd0);

        // 4: round robin; last grant was ch1 so ch0 goes first
        BUSY = 1'b1;
        bus_write(1'b0, 4'd11, 32'h1);
        bus_write(1'b1, 4'd11, 32'h1);
        for (int i = 0; i < 4; i++) bus_write(1'b0, 4'd5, 32'h300 + 32'(i));
        for (int i = 0; i < 4; i++) bus_write(1'b1, 4'd5, 32'h310 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            video_sb.push_back(32'h300 + 32'(i));
            video_sb.push_back(32'h310 + 32'(i));
        end
        idle(2);
        check("video_held_while_wait", 128'(VIDEO_BASE), 128'h200);
        BUSY = 1'b0;
        idle(12);
        check("video_rr_last", 128'(VIDEO_BASE), 128'h313);

        // 5: fence wait on ch0 fence >= 5
        bus_write(1'b1, 4'd12, 32'h0000_0005);
        video_sb.push_back(32'h400);
        bus_write(1'b1, 4'd5, 32'h400);
        idle(5);
        check("fence_blocked_video", 128'(VIDEO_BASE), 128'h313);
        check_read("status1_fence_wait", 1'b1, 4'd0, 32'h4948_0610);
        @(negedge CLK);
        bus_write(1'b0, 4'd10, 32'd4);
        idle(4);
        check_read("fence0_read", 1'b0, 4'd1, 32'd4);
        check("fence_below_blocked", 128'(VIDEO_BASE), 128'h313);
        @(negedge CLK);
        bus_write(1'b0, 4'd10, 32'd5);
        idle(4);
        check("fence_released_video", 128'(VIDEO_BASE), 128'h400);

        // Interrupt and cache clear from ch1
        bus_write(1'b1, 4'd9, 32'h3);
        @(negedge CLK);
        check("intr_pulse", 128'({INTR, CACHE_LUT_CLEAR, INTR_CH}), 128'h7);
        @(negedge CLK);
        check("intr_end", 128'({INTR, CACHE_LUT_CLEAR}), 128'd0);

        // 6: reset mid-transfer
        BUSY = 1'b1;
        bus_write(1'b1, 4'd11, 32'h1);
        bus_write(1'b1, 4'd5, 32'h500);
        mem_sb.push_back({32'hC3, 32'hC2, 32'hC1, 32'hC0});
        for (int k = 0; k < 4; k++) bus_write(1'b0, 4'(k), 32'hC0 + 32'(k));
        idle(2);
        check("mem_en_before_rst", 128'(MEM_EN), 128'd1);
        #2 nRST = 1'b0;
        BUSY = 1'b0;
        #1;
        check("rst_mid_mem_en", 128'(MEM_EN), 128'd0);
        check("rst_mid_clear", 128'(CACHE_LUT_CLEAR), 128'd1);
        check("rst_mid_video", 128'(VIDEO_BASE), 128'd0);
        check("rst_mid_thread", 128'({THREAD_EN, THREAD_OP, THREAD_PC}), 128'd0);
        check("rst_mid_desc", MEM_DESC, 128'd0);
        @(negedge CLK);
        #2 nRST = 1'b1;
        @(negedge CLK);
        check("clear_after_rst2", 128'(CACHE_LUT_CLEAR), 128'd0);
        idle(5);
        check_read("status0_after_rst", 1'b0, 4'd0, 32'h0000_0604);
        check_read("status1_after_rst", 1'b1, 4'd0, 32'h0000_0604);
        check("video_after_rst", 128'(VIDEO_BASE), 128'd0);

        check("mem_sb_empty", 128'(mem_sb.size()), 128'd0);
        check("thread_sb_empty", 128'(thread_sb.size()), 128'd0);
        check("video_sb_empty", 128'(video_sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
